// File: rtl/mipsfpga_ahb_lcd_spi_tx.sv
// Buffered SPI LCD transmitter: {RS, byte} FIFO feeding a mode-0, MSB-first serializer
// with per-byte chip select. Status (level/full/done/ovf) goes back to the GPIO read mux.
module mipsfpga_ahb_lcd_spi_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               wr_en,
    input  logic [8:0]         wr_data,
    input  logic               ovf_clr,
    output logic               full,
    output logic               done,
    output logic [FIFO_AW:0]   level,
    output logic               ovf,
    output logic               lcd_sck,
    output logic               lcd_sdo,
    output logic               lcd_rs,
    output logic               lcd_cs_n
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         edge_cnt_q, edge_cnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               sck_q, sck_d;
    logic               sdo_q, sdo_d;
    logic               rs_q, rs_d;
    logic               cs_n_q, cs_n_d;
    logic [8:0]         mem_q [DEPTH];
    logic [8:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               pop;
    logic               push;
    logic               drop;
    logic [8:0]         head;

    // Next-state: FIFO bookkeeping, status flags and the serializer FSM.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        shreg_d    = shreg_q;
        sck_d      = sck_q;
        sdo_d      = sdo_q;
        rs_d       = rs_q;
        cs_n_d     = cs_n_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;

        // The head is only consumed in LOAD, so a full FIFO can still take a push that cycle.
        pop  = (state_q == S_LOAD);
        push = wr_en && (!full_q || pop);
        drop = wr_en && full_q && !pop;
        head = mem_q[rd_ptr_q];

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_d    = head[7:0];
                rs_d       = head[8];
                sdo_d      = head[7];
                cs_n_d     = 1'b0;
                sck_d      = 1'b0;
                div_d      = '0;
                edge_cnt_d = '0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        // Sixteenth toggle is the trailing fall after bit 0: close the byte.
                        if (edge_cnt_q == 4'd15) begin
                            cs_n_d  = 1'b1;
                            sdo_d   = 1'b0;
                            state_d = S_GAP;
                        end else begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            sdo_d   = shreg_q[6];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        endcase

        full_d = (level_d == LVL_FULL);
        done_d = (level_d == '0) && (state_d == S_IDLE);
    end

    // State and output registers; reset aborts any byte in flight.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            edge_cnt_q <= '0;
            shreg_q    <= '0;
            sck_q      <= 1'b0;
            sdo_q      <= 1'b0;
            rs_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            done_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_cnt_q <= edge_cnt_d;
            shreg_q    <= shreg_d;
            sck_q      <= sck_d;
            sdo_q      <= sdo_d;
            rs_q       <= rs_d;
            cs_n_q     <= cs_n_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign full     = full_q;
    assign done     = done_q;
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign lcd_sck  = sck_q;
    assign lcd_sdo  = sdo_q;
    assign lcd_rs   = rs_q;
    assign lcd_cs_n = cs_n_q;

endmodule
